// File: rtl/tot_trigger_nch.sv
// tot_trigger_nch -- parametrised N-channel time-over-threshold trigger.
//
// Each sample, enabled channels above their threshold count as hits. When the
// hit count meets MULTIPLICITY, a single-bin bit is shifted into a WIDTH-deep
// sliding window. TRIG pulses for one clock once the window occupancy exceeds
// OCCUPANCY. The trigger then clears the window and its occupancy counter.
//
// Optional feature: define TOT_HOLDOFF_EN to add the HOLDOFF port. After each
// trigger the block stays disarmed for HOLDOFF samples. While it is disarmed,
// the window keeps running and is not cleared.
//
// Ports
//   CLK120        system clock
//   RESET_N       asynchronous reset, active low
//   SAMPLE_EN     strobe marking a valid sample (tie high for full rate)
//   ADC, THRES    NCH packed unsigned samples / thresholds, channel c at [c*ADC_W +: ADC_W]
//   TRIG_ENABLE   per-channel enable
//   MULTIPLICITY  channels required per bin; 0 disables the trigger
//   OCCUPANCY     TRIG fires when the occupancy is strictly greater than this
//   HOLDOFF       (TOT_HOLDOFF_EN only) re-arm holdoff in samples
//   TRIG          one-clock trigger pulse
//   SB_DEBUG      single-bin trigger bit
//   OCC_COUNT     current window occupancy
module tot_trigger_nch #(
    parameter  int NCH   = 3,
    parameter  int ADC_W = 12,
    parameter  int WIDTH = 122,
    localparam int OCC_W = $clog2(WIDTH + 1),
    localparam int MUL_W = $clog2(NCH + 1)
) (
    input  logic                 CLK120,
    input  logic                 RESET_N,
    input  logic                 SAMPLE_EN,
    input  logic [NCH*ADC_W-1:0] ADC,
    input  logic [NCH*ADC_W-1:0] THRES,
    input  logic [NCH-1:0]       TRIG_ENABLE,
    input  logic [MUL_W-1:0]     MULTIPLICITY,
    input  logic [OCC_W-1:0]     OCCUPANCY,
`ifdef TOT_HOLDOFF_EN
    input  logic [15:0]          HOLDOFF,
`endif
    output logic                 TRIG,
    output logic                 SB_DEBUG,
    output logic [OCC_W-1:0]     OCC_COUNT
);

    function automatic logic [MUL_W-1:0] hit_count(input logic [NCH-1:0] hits);
        logic [MUL_W-1:0] sum;
        sum = '0;
        for (int c = 0; c < NCH; c++) begin
            sum = sum + MUL_W'(hits[c]);
        end
        return sum;
    endfunction

`ifdef TOT_HOLDOFF_EN
    function automatic logic [15:0] dec_sat(input logic [15:0] v);
        return (v == 16'd0) ? 16'd0 : v - 16'd1;
    endfunction
`endif

    logic [NCH*ADC_W-1:0] adc_p1;
    logic [NCH*ADC_W-1:0] thres_p1;
    logic [NCH-1:0]       hit_p2;
    logic                 sb_p3;
    logic [WIDTH-1:0]     window_p4;
    logic [OCC_W-1:0]     occ_p4;
    logic                 trig_p5;

    logic [NCH-1:0]       hit_nxt;
    logic                 sb_nxt;
    logic                 win_out;
    logic [OCC_W-1:0]     occ_nxt;
    logic                 armed;
    logic                 fire;

    always_comb begin
        hit_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            hit_nxt[c] = (adc_p1[c*ADC_W +: ADC_W] > thres_p1[c*ADC_W +: ADC_W]) && TRIG_ENABLE[c];
        end
    end

    assign sb_nxt  = (MULTIPLICITY != '0) && (hit_count(hit_p2) >= MULTIPLICITY);
    assign win_out = window_p4[WIDTH-1];

    // Occupancy tracks entering minus leaving bits. It cannot pass WIDTH because only
    // WIDTH bits can be set in the window.
    always_comb begin
        occ_nxt = occ_p4;
        if (sb_p3 && !win_out) begin
            occ_nxt = occ_p4 + OCC_W'(1);
        end else if (win_out && !sb_p3) begin
            occ_nxt = occ_p4 - OCC_W'(1);
        end
    end

`ifdef TOT_HOLDOFF_EN
    logic [15:0] hoff_cnt;
    assign armed = (hoff_cnt == 16'd0);
`else
    assign armed = 1'b1;
`endif

    // A cleared count is 0, which can never exceed OCCUPANCY.
    // This keeps TRIG to a single clock.
    assign fire = armed && (occ_p4 > OCCUPANCY);

    // Stages 1-3: register inputs, per-channel hits, multiplicity decision
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            adc_p1   <= '0;
            thres_p1 <= '0;
            hit_p2   <= '0;
            sb_p3    <= 1'b0;
        end else if (SAMPLE_EN) begin
            adc_p1   <= ADC;
            thres_p1 <= THRES;
            hit_p2   <= hit_nxt;
            sb_p3    <= sb_nxt;
        end
    end

    // Stage 4: sliding window and occupancy; trigger clear overrides the sample update
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            window_p4 <= '0;
            occ_p4    <= '0;
            trig_p5   <= 1'b0;
        end else begin
            trig_p5 <= fire;
            if (fire) begin
                window_p4 <= '0;
                occ_p4    <= '0;
            end else if (SAMPLE_EN) begin
                window_p4 <= {window_p4[WIDTH-2:0], sb_p3};
                occ_p4    <= occ_nxt;
            end
        end
    end

`ifdef TOT_HOLDOFF_EN
    // Holdoff: a trigger loads HOLDOFF; each sample then counts it down to 0
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            hoff_cnt <= 16'd0;
        end else if (fire) begin
            hoff_cnt <= HOLDOFF;
        end else if (SAMPLE_EN) begin
            hoff_cnt <= dec_sat(hoff_cnt);
        end
    end
`endif

    assign TRIG      = trig_p5;
    assign SB_DEBUG  = sb_p3;
    assign OCC_COUNT = occ_p4;

endmodule

// File: tb/tb_tot_trigger_nch.sv
`timescale 1ns/1ps
module tb_tot_trigger_nch;
    localparam int NCH   = 3;
    localparam int ADC_W = 12;
    localparam int WIDTH = 122;
    localparam int OCC_W = $clog2(WIDTH + 1);
    localparam int MUL_W = $clog2(NCH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_en = 1'b0;
    logic [NCH*ADC_W-1:0] adc = '0;
    logic [NCH*ADC_W-1:0] thres = '0;
    logic [NCH-1:0]       trig_enable = '0;
    logic [MUL_W-1:0]     multiplicity = '0;
    logic [OCC_W-1:0]     occupancy = '0;
`ifdef TOT_HOLDOFF_EN
    logic [15:0]          holdoff = '0;
`endif
    logic                 trig;
    logic                 sb_debug;
    logic [OCC_W-1:0]     occ_count;

    int checks = 0;
    int failures = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    tot_trigger_nch #(.NCH(NCH), .ADC_W(ADC_W), .WIDTH(WIDTH)) dut (
        .CLK120      (clk),
        .RESET_N     (rst_n),
        .SAMPLE_EN   (sample_en),
        .ADC         (adc),
        .THRES       (thres),
        .TRIG_ENABLE (trig_enable),
        .MULTIPLICITY(multiplicity),
        .OCCUPANCY   (occupancy),
`ifdef TOT_HOLDOFF_EN
        .HOLDOFF     (holdoff),
`endif
        .TRIG        (trig),
        .SB_DEBUG    (sb_debug),
        .OCC_COUNT   (occ_count)
    );

    // ---------------- behavioural reference model ----------------
    // Samples move through capture -> hit decision -> bin decision -> window, one step
    // per strobe. The window is a queue of bits (front = newest), and the occupancy is
    // recomputed by summing it.
    logic [NCH*ADC_W-1:0] m_adc, m_thr;
    logic [NCH-1:0]       m_hit;
    bit                   m_sb;
    bit                   m_trig;
    bit                   m_win[$];
    int                   m_hoff;

    function automatic int m_occ();
        int s;
        s = 0;
        foreach (m_win[i]) s += int'(m_win[i]);
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_adc = '0; m_thr = '0; m_hit = '0; m_sb = 1'b0; m_trig = 1'b0; m_hoff = 0;
            m_win.delete();
            for (int i = 0; i < WIDTH; i++) m_win.push_back(1'b0);
        end else begin
            bit             fire;
            bit             new_sb;
            logic [NCH-1:0] new_hit;
            fire = (m_occ() > int'(occupancy)) && (m_hoff == 0);
            for (int c = 0; c < NCH; c++)
                new_hit[c] = (m_adc[c*ADC_W +: ADC_W] > m_thr[c*ADC_W +: ADC_W]) && trig_enable[c];
            new_sb = (multiplicity != 0) && ($countones(m_hit) >= int'(multiplicity));
            if (fire) begin
                foreach (m_win[i]) m_win[i] = 1'b0;
            end else if (sample_en) begin
                m_win.push_front(m_sb);
                void'(m_win.pop_back());
            end
            if (sample_en) begin
                m_sb = new_sb; m_hit = new_hit; m_adc = adc; m_thr = thres;
            end
            m_trig = fire;
`ifdef TOT_HOLDOFF_EN
            if (fire) m_hoff = int'(holdoff);
            else if (sample_en && m_hoff > 0) m_hoff = m_hoff - 1;
`endif
        end
    end

    always @(posedge clk) if (sample_en) strobes++;

    // Per-cycle compare against the model
    always @(negedge clk) begin
        checks++;
        if (trig !== m_trig || sb_debug !== m_sb || occ_count !== OCC_W'(m_occ())) begin
            failures++;
            $display("FAIL model_compare t=%0t trig=%0b exp=%0b sb=%0b exp=%0b occ=%0d exp=%0d",
                     $time, trig, m_trig, sb_debug, m_sb, occ_count, m_occ());
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [NCH*ADC_W-1:0] pack3(input int a0, input int a1, input int a2);
        logic [NCH*ADC_W-1:0] r;
        r = '0;
        r[0*ADC_W +: ADC_W] = ADC_W'(a0);
        r[1*ADC_W +: ADC_W] = ADC_W'(a1);
        r[2*ADC_W +: ADC_W] = ADC_W'(a2);
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reset, configure, let the pipeline settle on quiet data, then apply the test sample.
    // The i-th negedge after this returns follows the i-th posedge after the sample is applied.
    task automatic setup(input logic [NCH-1:0] en, input int mult, input int occ,
                         input logic [NCH*ADC_W-1:0] a);
        do_reset();
        sample_en    = 1'b1;
        thres        = pack3(100, 100, 100);
        trig_enable  = en;
        multiplicity = MUL_W'(mult);
        occupancy    = OCC_W'(occ);
        adc          = pack3(0, 0, 0);
`ifdef TOT_HOLDOFF_EN
        holdoff      = '0;
`endif
        repeat (6) @(negedge clk);
        adc = a;
    endtask

    task automatic run_obs(input int n, output int trigs, output int sbs, output int maxocc);
        trigs = 0; sbs = 0; maxocc = 0;
        repeat (n) begin
            @(negedge clk);
            trigs += int'(trig);
            sbs   += int'(sb_debug);
            if (int'(occ_count) > maxocc) maxocc = int'(occ_count);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int trigs, sbs, maxocc;
        int first_occ1, first_sb, occ13_at, trig_at, occ_at_trig;
        int rise, drop, zero, peak, prev_occ, prev_strobes, hold_bad, burst;
        int rand_trigs, mode;
        logic [NCH*ADC_W-1:0] hot;
        hot = pack3(101, 0, 0);

        // Reset state
        @(negedge clk);
        chk("reset_trig", int'(trig), 0);
        chk("reset_sb", int'(sb_debug), 0);
        chk("reset_occ", int'(occ_count), 0);

        // Equality with the threshold is not a hit
        setup(3'b111, 1, 12, pack3(100, 100, 100));
        run_obs(200, trigs, sbs, maxocc);
        chk("t1_trigs", trigs, 0);
        chk("t1_sb", sbs, 0);
        chk("t1_maxocc", maxocc, 0);

        // Single hot channel: latency, count to 13, trigger, clear
        setup(3'b001, 1, 12, hot);
        first_occ1 = -1; first_sb = -1; occ13_at = -1; trig_at = -1; occ_at_trig = -1; trigs = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (first_sb < 0 && sb_debug) first_sb = i;
            if (first_occ1 < 0 && occ_count == 1) first_occ1 = i;
            if (occ13_at < 0 && occ_count == 13) occ13_at = i;
            if (trig) begin
                trigs++;
                if (trig_at < 0) begin trig_at = i; occ_at_trig = int'(occ_count); end
            end
        end
        chk("t2_sb_latency", first_sb, 3);
        chk("t2_window_latency", first_occ1, 4);
        chk("t2_occ13_at", occ13_at, 16);
        chk("t2_trig_at", trig_at, 17);
        chk("t2_occ_after_trig", occ_at_trig, 0);
        chk("t2_trig_count", trigs, 1);

        // Multiplicity not met / channel disabled / multiplicity 0
        setup(3'b001, 2, 12, hot);
        run_obs(60, trigs, sbs, maxocc);
        chk("t3_mult2_sb", sbs, 0);
        chk("t3_mult2_trigs", trigs, 0);
        setup(3'b000, 1, 12, hot);
        run_obs(60, trigs, sbs, maxocc);
        chk("t3_disabled_sb", sbs, 0);
        chk("t3_disabled_trigs", trigs, 0);
        setup(3'b001, 0, 12, hot);
        run_obs(60, trigs, sbs, maxocc);
        chk("t3_mult0_trigs", trigs, 0);
        chk("t3_mult0_occ", maxocc, 0);
        // Two hot enabled channels meet multiplicity 2: triggers at 17, 31, 45, 59
        setup(3'b011, 2, 12, pack3(101, 101, 0));
        run_obs(60, trigs, sbs, maxocc);
        chk("t3_mult2_met_trigs", trigs, 4);

        // Decimated strobes: 5-sample burst travels the whole window
        setup(3'b001, 1, 10, pack3(0, 0, 0));
        sample_en = 1'b0;
        rise = -1; drop = -1; zero = -1; peak = 0; prev_occ = 0; hold_bad = 0; burst = 0;
        prev_strobes = strobes;
        for (int i = 0; i < 3 * 140; i++) begin
            @(negedge clk);
            if (strobes == prev_strobes && int'(occ_count) != prev_occ) hold_bad++;
            if (rise < 0 && occ_count == 1) rise = strobes;
            if (rise >= 0 && drop < 0 && int'(occ_count) < prev_occ) drop = strobes;
            if (rise >= 0 && zero < 0 && occ_count == 0) zero = strobes;
            if (int'(occ_count) > peak) peak = int'(occ_count);
            prev_occ = int'(occ_count);
            prev_strobes = strobes;
            sample_en = (i % 3 == 0);
            if (sample_en) begin
                adc = (burst < 5) ? hot : pack3(0, 0, 0);
                burst++;
            end
        end
        chk("t4_peak", peak, 5);
        chk("t4_first_drop", drop - rise, WIDTH);
        chk("t4_back_to_zero", zero - rise, WIDTH + 4);
        chk("t4_hold_between", hold_bad, 0);

        // Async reset mid-window, then OCCUPANCY = WIDTH never fires and count saturates at WIDTH
        setup(3'b001, 1, WIDTH, hot);
        for (int i = 0; i < 200 && occ_count != 40; i++) @(negedge clk);
        chk("t5_reach40", int'(occ_count), 40);
        chk("t5_sb_before", int'(sb_debug), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t5_async_occ", int'(occ_count), 0);
        chk("t5_async_sb", int'(sb_debug), 0);
        chk("t5_async_trig", int'(trig), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_obs(160, trigs, sbs, maxocc);
        chk("t5_full_trigs", trigs, 0);
        chk("t5_full_occ", int'(occ_count), WIDTH);

`ifdef TOT_HOLDOFF_EN
        // Holdoff of 200 samples with continuous hits
        setup(3'b001, 1, 12, hot);
        holdoff = 16'd200;
        trig_at = -1; occ13_at = -1;
        for (int i = 1; i <= 450; i++) begin
            @(negedge clk);
            if (trig) begin
                if (trig_at < 0) trig_at = i;
                else if (occ13_at < 0) occ13_at = i;
            end
        end
        chk("t6_first_trig", trig_at, 17);
        chk("t6_second_trig", occ13_at, 218);
        chk("t6_gap_ge_200", int'(occ13_at - trig_at >= 200), 1);
        holdoff = '0;
`endif

        // Randomised run against the model
        do_reset();
        rand_trigs = 0; mode = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rand_trigs += int'(trig);
            if (i % 250 == 0) begin
                mode         = int'($urandom_range(0, 2));
                trig_enable  = NCH'($urandom);
                multiplicity = MUL_W'($urandom_range(0, 3));
                occupancy    = OCC_W'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 60) == 0)
                occupancy = ($urandom_range(0, 9) == 0) ? OCC_W'(WIDTH) : OCC_W'($urandom_range(0, 40));
            if ($urandom_range(0, 80) == 0) multiplicity = MUL_W'($urandom_range(0, 3));
            sample_en = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (i % 3 == 0);
            for (int c = 0; c < NCH; c++) begin
                int t;
                t = 100 + int'($urandom_range(0, 3));
                thres[c*ADC_W +: ADC_W] = ADC_W'(t);
                adc[c*ADC_W +: ADC_W]   = ADC_W'(t + int'($urandom_range(0, 2)) - 1);
            end
        end
        chk("rand_trig_seen", int'(rand_trigs > 0), 1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
